// File: rtl/trap_ctrl_n.sv
// trap_ctrl_n: machine-mode trap controller.
// Arbitrates synchronous exceptions against NUM_IRQ maskable interrupt lines,
// sequences the mstatus/mepc/mcause/mtval CSR writes, redirects the PC to the
// handler and reports interrupt completion on mret.
// Optional feature macro: TRAP_VECTORED_EN (vectored interrupt entry when
// mtvec[1:0]==2'b01). Without it the handler is always the mtvec base.
module trap_ctrl_n #(
  parameter int XLEN     = 32,
  parameter int NUM_IRQ  = 16,
  parameter int IRQ_BASE = 2,
  parameter int IDW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XLEN-1:0]    csr_rdata_i,
  output logic [XLEN-1:0]    csr_wdata_o,
  output logic               csr_we_o,
  output logic [11:0]        csr_addr_o,
  input  logic               exc_valid_i,
  input  logic [4:0]         exc_code_i,
  input  logic [XLEN-1:0]    exc_tval_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               mie_i,
  input  logic               wfi_i,
  input  logic               mret_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    pc_n_i,
  output logic [XLEN-1:0]    pc_n_o,
  output logic               trap_jump_o,
  output logic               trap_in_o,
  output logic [NUM_IRQ-1:0] irq_ack_o,
  output logic               irq_cplt_o,
  output logic [IDW-1:0]     irq_cplt_id_o
);

  // Cause code width: wide enough for the largest interrupt code, never below 5.
  localparam int CW = ((IRQ_BASE + NUM_IRQ) > 32) ? $clog2(IRQ_BASE + NUM_IRQ) : 5;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE,
    SWFI,
    CMIE,
    WEPC,
    WCAU,
    WTVL,
    JUMP
  } state_t;

  state_t state, state_nxt;

  logic [NUM_IRQ-1:0] pend;
  logic [IDW-1:0]     winner;
  logic               take;

  logic               is_irq_q;
  logic [CW-1:0]      code_q;
  logic [XLEN-1:0]    tval_q;
  logic [XLEN-1:0]    epc_q;
  logic [IDW-1:0]     id_q;

  logic               insvc;
  logic [IDW-1:0]     insvc_id;
  logic               ack_any;
  logic               cplt_now;
  logic [XLEN-1:0]    mtvec_base;
  logic [XLEN-1:0]    handler_pc;

  assign pend    = irq_i & irq_en_i;
  assign take    = exc_valid_i | (mie_i & (|pend));
  assign ack_any = (state == CMIE) && is_irq_q;
  assign cplt_now = mret_i & insvc;

  assign irq_ack_o  = ack_any ? (NUM_IRQ'(1) << id_q) : '0;
  assign mtvec_base = {csr_rdata_i[XLEN-1:2], 2'b00};

  // Priority encoder: the lowest-numbered pending line wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) winner = IDW'(i);
    end
  end

  // Handler address from mtvec, optionally offset by the interrupt cause.
  always_comb begin
    handler_pc = mtvec_base;
`ifdef TRAP_VECTORED_EN
    if (is_irq_q && (csr_rdata_i[1:0] == 2'b01)) begin
      handler_pc = mtvec_base + (XLEN'(code_q) << 2);
    end
`endif
  end

  // State register; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: wait/idle decisions, then a fixed five-cycle write sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take)       state_nxt = CMIE;
        else if (wfi_i) state_nxt = SWFI;
      end
      SWFI: begin
        if (take)        state_nxt = CMIE;
        else if (|pend)  state_nxt = IDLE;
      end
      CMIE:    state_nxt = WEPC;
      WEPC:    state_nxt = WCAU;
      WCAU:    state_nxt = WTVL;
      WTVL:    state_nxt = JUMP;
      JUMP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the trap context on entry so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_irq_q <= 1'b0;
      code_q   <= '0;
      tval_q   <= '0;
      epc_q    <= '0;
      id_q     <= '0;
    end else if (state_nxt == CMIE) begin
      is_irq_q <= !exc_valid_i;
      code_q   <= exc_valid_i ? CW'(exc_code_i) : (CW'(IRQ_BASE) + CW'(winner));
      tval_q   <= exc_valid_i ? exc_tval_i : '0;
      epc_q    <= pc_i;
      id_q     <= winner;
    end
  end

  // CSR write strobes, stall and PC redirect decoded from the current state.
  always_comb begin
    csr_we_o    = 1'b0;
    csr_addr_o  = '0;
    csr_wdata_o = '0;
    trap_jump_o = 1'b0;
    trap_in_o   = 1'b0;
    pc_n_o      = pc_n_i;
    case (state)
      IDLE: trap_in_o = take;
      SWFI: trap_in_o = 1'b1;
      CMIE: begin
        trap_in_o      = 1'b1;
        csr_we_o       = 1'b1;
        csr_addr_o     = ADDR_MSTATUS;
        csr_wdata_o    = csr_rdata_i;
        csr_wdata_o[7] = csr_rdata_i[3];
        csr_wdata_o[3] = 1'b0;
      end
      WEPC: begin
        trap_in_o   = 1'b1;
        csr_we_o    = 1'b1;
        csr_addr_o  = ADDR_MEPC;
        csr_wdata_o = epc_q;
      end
      WCAU: begin
        trap_in_o   = 1'b1;
        csr_we_o    = 1'b1;
        csr_addr_o  = ADDR_MCAUSE;
        csr_wdata_o = {is_irq_q, (XLEN-1)'(code_q)};
      end
      WTVL: begin
        trap_in_o   = 1'b1;
        csr_we_o    = 1'b1;
        csr_addr_o  = ADDR_MTVAL;
        csr_wdata_o = tval_q;
      end
      JUMP: begin
        trap_in_o   = 1'b1;
        trap_jump_o = 1'b1;
        csr_addr_o  = ADDR_MTVEC;
        pc_n_o      = handler_pc;
      end
      default: ;
    endcase
  end

  // In-service tracking: completion reports the old id even when a new accept lands the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insvc         <= 1'b0;
      insvc_id      <= '0;
      irq_cplt_o    <= 1'b0;
      irq_cplt_id_o <= '0;
    end else begin
      irq_cplt_o <= cplt_now;
      if (cplt_now) irq_cplt_id_o <= insvc_id;
      if (ack_any) begin
        insvc    <= 1'b1;
        insvc_id <= id_q;
      end else if (cplt_now) begin
        insvc <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl_n.sv
// tb_trap_ctrl_n: self-checking bench for trap_ctrl_n.
// Directed vector table, hand-written multi-cycle sequences (WFI, completion,
// reset mid-sequence) and random traps checked against a transaction model.
// Honours TRAP_VECTORED_EN the same way as the design.
module tb_trap_ctrl_n;

  localparam int XLEN = 32;
  localparam int NUM_IRQ = 16;
  localparam int IDW = 4;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] T_PRIO = 32'h0000_0218;
  localparam logic [31:0] T_L0   = 32'h0000_8008;
`else
  localparam logic [31:0] T_PRIO = 32'h0000_0200;
  localparam logic [31:0] T_L0   = 32'h0000_8000;
`endif

  logic               clk;
  logic               rst_n;
  logic [XLEN-1:0]    csr_rdata_i;
  logic [XLEN-1:0]    csr_wdata_o;
  logic               csr_we_o;
  logic [11:0]        csr_addr_o;
  logic               exc_valid_i;
  logic [4:0]         exc_code_i;
  logic [XLEN-1:0]    exc_tval_i;
  logic [NUM_IRQ-1:0] irq_i;
  logic [NUM_IRQ-1:0] irq_en_i;
  logic               mie_i;
  logic               wfi_i;
  logic               mret_i;
  logic [XLEN-1:0]    pc_i;
  logic [XLEN-1:0]    pc_n_i;
  logic [XLEN-1:0]    pc_n_o;
  logic               trap_jump_o;
  logic               trap_in_o;
  logic [NUM_IRQ-1:0] irq_ack_o;
  logic               irq_cplt_o;
  logic [IDW-1:0]     irq_cplt_id_o;

  logic [31:0] mstatus_m;
  logic [31:0] mtvec_m;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_tval;
    logic [15:0] irq;
    logic [15:0] irq_en;
    logic        mie;
    logic [31:0] pc;
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic        taken;
    logic [15:0] ack;
    logic [31:0] mstatus_w;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] target;
  } vec_t;

  vec_t tbl[7];

  trap_ctrl_n #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .IRQ_BASE(2), .IDW(IDW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_rdata_i   (csr_rdata_i),
    .csr_wdata_o   (csr_wdata_o),
    .csr_we_o      (csr_we_o),
    .csr_addr_o    (csr_addr_o),
    .exc_valid_i   (exc_valid_i),
    .exc_code_i    (exc_code_i),
    .exc_tval_i    (exc_tval_i),
    .irq_i         (irq_i),
    .irq_en_i      (irq_en_i),
    .mie_i         (mie_i),
    .wfi_i         (wfi_i),
    .mret_i        (mret_i),
    .pc_i          (pc_i),
    .pc_n_i        (pc_n_i),
    .pc_n_o        (pc_n_o),
    .trap_jump_o   (trap_jump_o),
    .trap_in_o     (trap_in_o),
    .irq_ack_o     (irq_ack_o),
    .irq_cplt_o    (irq_cplt_o),
    .irq_cplt_id_o (irq_cplt_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal CSR file: answers reads of mstatus and mtvec.
  always_comb begin
    csr_rdata_i = 32'h0;
    if (csr_addr_o == 12'h300)      csr_rdata_i = mstatus_m;
    else if (csr_addr_o == 12'h305) csr_rdata_i = mtvec_m;
  end

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Transaction model: what a trap taken from this snapshot must write and where it jumps.
  function automatic vec_t ref_model(input vec_t s);
    vec_t r;
    logic [15:0] pend;
    logic [15:0] low;
    int idx;
    r = s;
    pend = s.irq & s.irq_en;
    low = pend & (~pend + 16'd1);
    idx = 0;
    while (low > 16'd1) begin
      low = low >> 1;
      idx++;
    end
    r.taken     = s.exc_valid || (s.mie && (pend != 16'd0));
    r.ack       = 16'd0;
    r.mepc      = s.pc;
    r.mstatus_w = (s.mstatus & ~32'h88) | ((s.mstatus & 32'h8) << 4);
    r.target    = s.mtvec & ~32'h3;
    if (s.exc_valid) begin
      r.mcause = 32'(s.exc_code);
      r.mtval  = s.exc_tval;
    end else begin
      r.ack    = r.taken ? (16'd1 << idx) : 16'd0;
      r.mcause = 32'h8000_0000 + 32'(2 + idx);
      r.mtval  = 32'd0;
`ifdef TRAP_VECTORED_EN
      if (s.mtvec[1:0] == 2'b01) r.target = (s.mtvec & ~32'h3) + 32'(4 * (2 + idx));
`endif
    end
    return r;
  endfunction

  task automatic driveIdle();
    exc_valid_i = 1'b0;
    exc_code_i  = 5'd0;
    exc_tval_i  = 32'd0;
    irq_i       = 16'd0;
    irq_en_i    = 16'd0;
    mie_i       = 1'b0;
    wfi_i       = 1'b0;
    mret_i      = 1'b0;
    pc_i        = 32'h0000_0040;
    pc_n_i      = 32'h0000_0044;
  endtask

  task automatic applyStimulus(input vec_t v);
    exc_valid_i = v.exc_valid;
    exc_code_i  = v.exc_code;
    exc_tval_i  = v.exc_tval;
    irq_i       = v.irq;
    irq_en_i    = v.irq_en;
    mie_i       = v.mie;
    wfi_i       = 1'b0;
    mret_i      = 1'b0;
    pc_i        = v.pc;
    pc_n_i      = v.pc + 32'd4;
    mstatus_m   = v.mstatus;
    mtvec_m     = v.mtvec;
  endtask

  // Called just after a falling edge with stimulus applied; walks the whole trap sequence.
  task automatic checkOutput(input vec_t v, input string name, input bit mret_at_cmie,
                             input logic [IDW-1:0] old_id);
    #1;
    compare($sformatf("%s/trap_in", name), trap_in_o, v.taken);
    compare($sformatf("%s/pc_pass", name), pc_n_o, pc_n_i);
    if (v.taken) begin
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        @(negedge clk);
        exc_valid_i = 1'($urandom);
        exc_code_i  = 5'($urandom);
        exc_tval_i  = $urandom;
        irq_i       = 16'($urandom);
        irq_en_i    = 16'($urandom);
        mie_i       = 1'($urandom);
        wfi_i       = 1'($urandom);
        pc_i        = $urandom;
        pc_n_i      = $urandom;
        mret_i      = (k == 0) && mret_at_cmie;
        #1;
        compare($sformatf("%s/stall%0d", name, k), trap_in_o, 1'b1);
        compare($sformatf("%s/ack%0d", name, k), irq_ack_o, (k == 0) ? v.ack : 16'd0);
        case (k)
          0: compare($sformatf("%s/mstatus_wr", name), {csr_we_o, csr_addr_o, csr_wdata_o},
                     {1'b1, 12'h300, v.mstatus_w});
          1: begin
            compare($sformatf("%s/mepc_wr", name), {csr_we_o, csr_addr_o, csr_wdata_o},
                    {1'b1, 12'h341, v.mepc});
            compare($sformatf("%s/cplt", name), {irq_cplt_o, irq_cplt_id_o},
                    mret_at_cmie ? {1'b1, old_id} : {1'b0, irq_cplt_id_o});
          end
          2: compare($sformatf("%s/mcause_wr", name), {csr_we_o, csr_addr_o, csr_wdata_o},
                     {1'b1, 12'h342, v.mcause});
          3: compare($sformatf("%s/mtval_wr", name), {csr_we_o, csr_addr_o, csr_wdata_o},
                     {1'b1, 12'h343, v.mtval});
          default: compare($sformatf("%s/jump", name),
                           {trap_jump_o, csr_we_o, csr_addr_o, pc_n_o},
                           {1'b1, 1'b0, 12'h305, v.target});
        endcase
        if (k < 4) compare($sformatf("%s/pc_pass%0d", name, k), {trap_jump_o, pc_n_o}, {1'b0, pc_n_i});
      end
    end
    @(posedge clk);
    @(negedge clk);
    driveIdle();
    #1;
    compare($sformatf("%s/post", name), {trap_in_o, csr_we_o, irq_ack_o, trap_jump_o}, 64'd0);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;

    tbl[0] = '{1'b1, 5'd2, 32'hDEAD0013, 16'h0000, 16'h0000, 1'b0, 32'h100, 32'h88, 32'h200,
               1'b1, 16'h0000, 32'h80, 32'h100, 32'h0000_0002, 32'hDEAD0013, 32'h200};
    tbl[1] = '{1'b0, 5'd0, 32'h0, 16'h0030, 16'hFFFF, 1'b1, 32'h400, 32'h08, 32'h201,
               1'b1, 16'h0010, 32'h80, 32'h400, 32'h8000_0006, 32'h0, T_PRIO};
    tbl[2] = '{1'b0, 5'd0, 32'h0, 16'h0001, 16'hFFFF, 1'b0, 32'h500, 32'h08, 32'h200,
               1'b0, 16'h0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 5'd0, 32'h0, 16'h0008, 16'h0007, 1'b1, 32'h600, 32'h08, 32'h200,
               1'b0, 16'h0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 5'd0, 32'h0, 16'h8000, 16'hFFFF, 1'b1, 32'h700, 32'h00, 32'h1000,
               1'b1, 16'h8000, 32'h00, 32'h700, 32'h8000_0011, 32'h0, 32'h1000};
    tbl[5] = '{1'b1, 5'd11, 32'h0, 16'h0001, 16'hFFFF, 1'b1, 32'h800, 32'hFFFF_FFFF, 32'h301,
               1'b1, 16'h0000, 32'hFFFF_FFF7, 32'h800, 32'h0000_000B, 32'h0, 32'h300};
    tbl[6] = '{1'b0, 5'd0, 32'h0, 16'h0001, 16'h0001, 1'b1, 32'h900, 32'h80, 32'h8001,
               1'b1, 16'h0001, 32'h00, 32'h900, 32'h8000_0002, 32'h0, T_L0};

    driveIdle();
    mstatus_m = 32'h0;
    mtvec_m   = 32'h0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    compare("reset/csr", {csr_we_o, csr_addr_o, csr_wdata_o}, 64'd0);
    compare("reset/ctl", {trap_jump_o, trap_in_o, irq_ack_o}, 64'd0);
    compare("reset/cplt", {irq_cplt_o, irq_cplt_id_o}, 64'd0);
    compare("reset/pc", pc_n_o, pc_n_i);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], $sformatf("vec%0d", i), 1'b0, '0);
    end

    $display("[TB] wfi with interrupts masked");
    wfi_i = 1'b1;
    stepCycle();
    wfi_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      compare($sformatf("swfi_hold%0d", k), {trap_in_o, csr_we_o}, 2'b10);
      stepCycle();
    end
    irq_i    = 16'h0001;
    irq_en_i = 16'hFFFF;
    stepCycle();
    #1;
    compare("wake_no_trap", {trap_in_o, csr_we_o, irq_ack_o}, 64'd0);
    stepCycle();
    #1;
    compare("wake_stay_idle", {trap_in_o, csr_we_o, irq_ack_o}, 64'd0);
    driveIdle();

    $display("[TB] wfi wake into trap");
    mie_i = 1'b1;
    wfi_i = 1'b1;
    stepCycle();
    wfi_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      compare($sformatf("wfi_wait%0d", k), {trap_in_o, csr_we_o}, 2'b10);
      stepCycle();
    end
    v = '{1'b0, 5'd0, 32'h0, 16'h0008, 16'hFFFF, 1'b1, 32'hA00, 32'h08, 32'h400,
          1'b1, 16'h0008, 32'h80, 32'hA00, 32'h8000_0005, 32'h0, 32'h400};
    applyStimulus(v);
    checkOutput(v, "wfi_wake", 1'b0, '0);

    $display("[TB] completion");
    v = '{1'b0, 5'd0, 32'h0, 16'h0080, 16'hFFFF, 1'b1, 32'hB00, 32'h08, 32'h400,
          1'b1, 16'h0080, 32'h80, 32'hB00, 32'h8000_0009, 32'h0, 32'h400};
    applyStimulus(v);
    checkOutput(v, "line7", 1'b0, '0);
    mret_i = 1'b1;
    stepCycle();
    mret_i = 1'b0;
    #1;
    compare("cplt_line7", {irq_cplt_o, irq_cplt_id_o}, {1'b1, 4'd7});
    stepCycle();
    #1;
    compare("cplt_one_cycle", irq_cplt_o, 1'b0);
    mret_i = 1'b1;
    stepCycle();
    mret_i = 1'b0;
    #1;
    compare("second_mret", irq_cplt_o, 1'b0);

    $display("[TB] mret coincident with accept");
    v = '{1'b0, 5'd0, 32'h0, 16'h0004, 16'hFFFF, 1'b1, 32'hC00, 32'h00, 32'h400,
          1'b1, 16'h0004, 32'h00, 32'hC00, 32'h8000_0004, 32'h0, 32'h400};
    applyStimulus(v);
    checkOutput(v, "line2", 1'b0, '0);
    v = '{1'b0, 5'd0, 32'h0, 16'h0020, 16'hFFFF, 1'b1, 32'hD00, 32'h00, 32'h400,
          1'b1, 16'h0020, 32'h00, 32'hD00, 32'h8000_0007, 32'h0, 32'h400};
    applyStimulus(v);
    checkOutput(v, "line5_mret", 1'b1, 4'd2);
    mret_i = 1'b1;
    stepCycle();
    mret_i = 1'b0;
    #1;
    compare("cplt_line5", {irq_cplt_o, irq_cplt_id_o}, {1'b1, 4'd5});

    $display("[TB] exception beats interrupt, interrupt after mret");
    v = '{1'b1, 5'd3, 32'h0, 16'h0001, 16'h0001, 1'b1, 32'hE00, 32'h08, 32'h200,
          1'b1, 16'h0000, 32'h80, 32'hE00, 32'h0000_0003, 32'h0, 32'h200};
    applyStimulus(v);
    checkOutput(v, "simul_exc", 1'b0, '0);
    irq_i    = 16'h0001;
    irq_en_i = 16'h0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      compare($sformatf("handler_masked%0d", k), {trap_in_o, csr_we_o}, 2'b00);
      stepCycle();
    end
    mret_i = 1'b1;
    stepCycle();
    v = '{1'b0, 5'd0, 32'h0, 16'h0001, 16'h0001, 1'b1, 32'hE04, 32'h08, 32'h200,
          1'b1, 16'h0001, 32'h80, 32'hE04, 32'h8000_0002, 32'h0, 32'h200};
    applyStimulus(v);
    checkOutput(v, "simul_irq", 1'b0, '0);

    $display("[TB] reset mid-sequence");
    v = '{1'b0, 5'd0, 32'h0, 16'h0002, 16'hFFFF, 1'b1, 32'hF00, 32'h08, 32'h200,
          1'b1, 16'h0002, 32'h80, 32'hF00, 32'h8000_0003, 32'h0, 32'h200};
    applyStimulus(v);
    stepCycle();
    driveIdle();
    #1;
    compare("rst_mid/ack", irq_ack_o, 16'h0002);
    stepCycle();
    #1;
    rst_n = 1'b0;
    #1;
    compare("rst_mid/outs", {csr_we_o, trap_in_o, trap_jump_o, irq_ack_o}, 64'd0);
    compare("rst_mid/pc", pc_n_o, pc_n_i);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      stepCycle();
      #1;
      compare($sformatf("rst_mid/quiet%0d", k), {csr_we_o, trap_in_o, trap_jump_o}, 64'd0);
    end
    mret_i = 1'b1;
    stepCycle();
    mret_i = 1'b0;
    #1;
    compare("rst_mid/no_cplt", irq_cplt_o, 1'b0);

    $display("[TB] random traps against model");
    for (int i = 0; i < 40; i++) begin
      v.exc_valid = ($urandom_range(0, 3) == 0);
      v.exc_code  = 5'($urandom);
      v.exc_tval  = $urandom;
      v.irq       = 16'($urandom & $urandom);
      v.irq_en    = 16'($urandom);
      v.mie       = 1'($urandom_range(0, 1));
      v.pc        = $urandom & ~32'h3;
      v.mstatus   = $urandom;
      v.mtvec     = ($urandom & ~32'h3) | 32'($urandom_range(0, 3));
      v = ref_model(v);
      applyStimulus(v);
      checkOutput(v, $sformatf("rnd%0d", i), 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
